// File: rtl/async_req_injector.sv
// Clocked-to-async entry stage: FIFO-buffered words launched as 4-phase bundled-data handshakes.
// Optional ack watchdog enabled by defining ACK_TIMEOUT_EN.
module async_req_injector #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic [DATA_W-1:0]        data_out,
    output logic                     req_out,
    input  logic                     ack_in,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(SETUP_CYC + 1);
    localparam int FW   = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_REQ_HI = 3'd3,
        ST_REQ_LO = 3'd4
    } state_t;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (SETUP_CYC < 1) ||
        (SYNC_STAGES < 2) || (TIMEOUT < 1)) begin : g_bad_params
        $error("async_req_injector: illegal parameter set");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CNTW-1:0]         r_count;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic [FW-1:0]           r_fill;
    logic [CW-1:0]           r_setup;
    logic [DATA_W-1:0]       r_data;
    logic                    r_req;
    logic                    w_ack_s;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_req_nxt;

    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign in_ready = (r_count != CNTW'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign count    = r_count;
    assign data_out = r_data;
    assign req_out  = r_req;
    assign busy     = ((r_state != ST_IDLE) && (r_state != ST_RESYNC)) || (r_count != CNTW'(0));

    // ack_in crosses from the async domain; only the last stage is ever used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RESYNC must first let the synchroniser fill, otherwise a high ack held through reset looks low
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESYNC: begin
                if ((r_fill == FW'(SYNC_STAGES)) && !w_ack_s) w_state_nxt = ST_IDLE;
                else                                          w_state_nxt = ST_RESYNC;
            end
            ST_IDLE: begin
                if (r_count != CNTW'(0)) w_state_nxt = ST_SETUP;
                else                     w_state_nxt = ST_IDLE;
            end
            ST_SETUP: begin
                if (r_setup == CW'(0)) w_state_nxt = ST_REQ_HI;
                else                   w_state_nxt = ST_SETUP;
            end
            ST_REQ_HI: begin
                if (w_ack_s) w_state_nxt = ST_REQ_LO;
                else         w_state_nxt = ST_REQ_HI;
            end
            ST_REQ_LO: begin
                if (!w_ack_s) w_state_nxt = ST_IDLE;
                else          w_state_nxt = ST_REQ_LO;
            end
            default: w_state_nxt = ST_RESYNC;
        endcase
    end

    always_comb begin
        w_pop     = (r_state == ST_IDLE) && (r_count != CNTW'(0));
        w_req_nxt = (w_state_nxt == ST_REQ_HI);
    end

    // req_out comes straight from a flop so the C-element never sees a glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_data  <= '0;
            r_setup <= '0;
            r_fill  <= '0;
        end else begin
            r_req <= w_req_nxt;
            if (w_pop) begin
                r_data  <= r_mem[r_rd_ptr];
                r_setup <= CW'(SETUP_CYC);
            end else if ((r_state == ST_SETUP) && (r_setup != CW'(0))) begin
                r_data  <= r_data;
                r_setup <= r_setup - CW'(1);
            end else begin
                r_data  <= r_data;
                r_setup <= r_setup;
            end
            if ((r_state == ST_RESYNC) && (r_fill != FW'(SYNC_STAGES))) r_fill <= r_fill + FW'(1);
            else                                                       r_fill <= r_fill;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            else        r_wr_ptr <= r_wr_ptr;
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            else       r_rd_ptr <= r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ACK_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] r_to_cnt;
    logic           r_err;
    logic           w_in_req;

    assign w_in_req = (r_state == ST_REQ_HI) || (r_state == ST_REQ_LO);
    assign err      = r_err;

    // watchdog only observes; a stuck handshake keeps waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_to_cnt <= '0;
                r_err    <= r_err;
            end else if (w_in_req && (r_to_cnt != TOW'(TIMEOUT))) begin
                r_to_cnt <= r_to_cnt + TOW'(1);
                r_err    <= r_err | (r_to_cnt == TOW'(TIMEOUT - 1));
            end else begin
                r_to_cnt <= r_to_cnt;
                r_err    <= r_err;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_async_req_injector.sv
// Randomised bench for async_req_injector against a transaction/timing model of the handshake.
module tb_async_req_injector;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SETUP_CYC   = 2;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] data_out;
    logic              req_out;
    logic              ack_in;
    logic              busy;
    logic [2:0]        count;
    logic              err;

    always #5 clk = ~clk;

    async_req_injector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC),
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .data_out(data_out), .req_out(req_out),
        .ack_in(ack_in), .busy(busy), .count(count), .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: words queued, the word on the bus, and where the handshake stands in time
    byte unsigned m_q[$];
    bit [7:0]     m_data;
    bit           m_open;      // launches allowed (downstream seen at zero after reset)
    int           m_warm;      // edges since reset, up to synchroniser depth
    bit           m_hs;        // a word is in flight
    int           m_setup;     // edges of bundling delay left, -1 once req has been raised
    bit           m_req;
    bit           m_hist[SYNC_STAGES]; // ack_in samples, [0] most recent
    int           m_wc;
    bit           m_err;

    function automatic void model_reset();
        m_q.delete();
        m_data = 8'h00; m_open = 1'b0; m_warm = 0; m_hs = 1'b0;
        m_setup = -1; m_req = 1'b0; m_wc = 0; m_err = 1'b0;
        for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] = 1'b0;
    endfunction

    function automatic void model_edge();
        bit ack_seen = m_hist[SYNC_STAGES-1];
        int sz       = m_q.size();
        bit waiting  = m_hs && (m_setup < 0);
        bit changed  = 1'b0;
        if (!m_open) begin
            if (m_warm >= SYNC_STAGES && !ack_seen) m_open = 1'b1;
            else if (m_warm < SYNC_STAGES)          m_warm++;
        end else if (!m_hs) begin
            if (sz > 0) begin
                m_data = m_q.pop_front(); m_hs = 1'b1; m_setup = SETUP_CYC;
            end
        end else if (m_setup > 0) begin
            m_setup--;
        end else if (m_setup == 0) begin
            m_setup = -1; m_req = 1'b1;
        end else if (m_req && ack_seen) begin
            m_req = 1'b0; changed = 1'b1;
        end else if (!m_req && !ack_seen) begin
            m_hs = 1'b0; changed = 1'b1;
        end
`ifdef ACK_TIMEOUT_EN
        if (waiting && !changed) begin
            if (m_wc < TIMEOUT) begin
                m_wc++;
                if (m_wc == TIMEOUT) m_err = 1'b1;
            end
        end else begin
            m_wc = 0;
        end
`else
        if (waiting && !changed) m_wc = 0;
`endif
        if (in_valid && sz != DEPTH) m_q.push_back(in_data);
        for (int k = SYNC_STAGES - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ack_in;
    endfunction

    task automatic check_outputs();
        chk("req_out",  req_out,  m_req);
        chk("data_out", data_out, m_data);
        chk("count",    count,    m_q.size());
        chk("in_ready", in_ready, (m_q.size() != DEPTH));
        chk("busy",     busy,     (m_hs || m_q.size() != 0));
        chk("err",      err,      m_err);
    endtask

    // Ack responder: follows req_out after a random number of cycles when enabled
    int ack_auto = 0;
    int dly      = 0;
    int dly_lo   = 0;
    int dly_hi   = 0;

    task automatic cycle(input bit v, input logic [7:0] d);
        if (ack_auto != 0 && ack_in != req_out) begin
            if (dly == 0) begin
                ack_in = req_out;
                dly    = $urandom_range(dly_hi, dly_lo);
            end else begin
                dly--;
            end
        end
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input bit ack_level);
        rst = 1'b1; in_valid = 1'b0; ack_in = ack_level;
        repeat (2) @(negedge clk);
        model_reset();
        check_outputs();
        rst = 1'b0;
    endtask

    int k;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_in = 1'b0;

        // reset, then RESYNC must clear before any launch
        do_reset(1'b0);
        repeat (4) cycle(1'b0, 8'h00);

        // single word with ack echoed after 3 clks
        ack_auto = 1; dly_lo = 3; dly_hi = 3; dly = 3;
        cycle(1'b1, 8'hA5);
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00);
        chk("t2_busy_end", busy, 0);

        // fill with ack stuck low; sixth push must be refused
        ack_auto = 0; ack_in = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h10 + 8'(i));
        chk("t3_count_full", count, DEPTH);
        chk("t3_in_ready", in_ready, 0);
        ack_auto = 1; dly_lo = 0; dly_hi = 4; dly = 1;
        for (int i = 0; i < 120; i++) cycle(1'b0, 8'h00);
        chk("t3_drained", count, 0);

        // ack high through reset release blocks launches
        ack_auto = 0;
        do_reset(1'b1);
        cycle(1'b1, 8'h3C);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
        chk("t4_no_req", req_out, 0);
        ack_in = 1'b0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00);
        ack_auto = 1; dly = 2;
        for (int i = 0; i < 25; i++) cycle(1'b0, 8'h00);

        // reset asserted while in REQ_HI with three words queued
        ack_auto = 0; ack_in = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h60 + 8'(i));
        k = 0;
        while (req_out !== 1'b1 && k < 20) begin cycle(1'b0, 8'h00); k++; end
        chk("t5_req_hi", req_out, 1);
        chk("t5_count3", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_req", req_out, 0);
        chk("t5_rst_count", count, 0);
        @(negedge clk);
        model_reset();
        check_outputs();
        rst = 1'b0;

        // randomised traffic with random ack delays
        ack_auto = 1; dly_lo = 0; dly_hi = 4; dly = 0;
        for (int i = 0; i < 400; i++) cycle(1'($urandom_range(1, 0)), 8'($urandom));
        for (int i = 0; i < 150; i++) cycle(1'b0, 8'h00);
        chk("rand_drained", busy, 0);

        // ack never answers
        ack_auto = 0; ack_in = 1'b0;
        cycle(1'b1, 8'hE7);
        k = 0;
        while (req_out !== 1'b1 && k < 20) begin cycle(1'b0, 8'h00); k++; end
        chk("t6_req_hi", req_out, 1);
        k = 0;
        while (err !== 1'b1 && k < TIMEOUT + 10) begin cycle(1'b0, 8'h00); k++; end
`ifdef ACK_TIMEOUT_EN
        chk("t6_err_latency", k, TIMEOUT);
        chk("t6_err", err, 1);
`else
        chk("t6_err_off", err, 0);
`endif
        chk("t6_req_held", req_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
